// File: rtl/envelope_pkg.sv
// envelope_pkg: shared definitions for the envelope_trigger block.
//   env_state_t : per-channel detector state (IDLE / ACTIVE / RELEASE)
//   bits_for()  : register width needed to hold the values 0..n-1 (minimum 1)
package envelope_pkg;

    typedef logic [1:0] env_state_t;

    localparam env_state_t IDLE    = 2'd0;
    localparam env_state_t ACTIVE  = 2'd1;
    localparam env_state_t RELEASE = 2'd2;

    function automatic int unsigned bits_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/envelope_trigger_if.sv
// envelope_trigger_if: sample input stream plus window-span result stream.
//   axiiv/axiid/axiic                : sample valid / data / channel index
//   span_axiov/span_axiod/span_axioc : span result pulse / span value / channel
//   master : the side that supplies samples and observes span results
//   slave  : the envelope_trigger side
interface envelope_trigger_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CHAN_W = 1
);
    logic              axiiv;
    logic [DATA_W-1:0] axiid;
    logic [CHAN_W-1:0] axiic;
    logic              span_axiov;
    logic [DATA_W-1:0] span_axiod;
    logic [CHAN_W-1:0] span_axioc;

    modport master (
        output axiiv, axiid, axiic,
        input  span_axiov, span_axiod, span_axioc
    );

    modport slave (
        input  axiiv, axiid, axiic,
        output span_axiov, span_axiod, span_axioc
    );
endinterface

// File: rtl/envelope_channel.sv
// envelope_channel: one channel of the envelope detector.
// Tracks min/max over tumbling windows of LOOK_BACK accepted samples and, at
// each window close, emits the span (max-min) for one cycle and steps the
// IDLE/ACTIVE/RELEASE hysteresis FSM.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous restart of window and FSM
//   sample_valid : a sample for this channel is accepted this cycle
//   sample_data  : sample value
//   span_valid   : one-cycle pulse after the closing sample
//   span         : max-min of the closed window
//   triggered    : FSM is ACTIVE or RELEASE
module envelope_channel
    import envelope_pkg::*;
#(
    parameter int unsigned SAMPLE_DATA_WIDTH = 8,
    parameter int unsigned LOOK_BACK         = 50,
    parameter int unsigned LOW_THRESHOLD     = 2,
    parameter int unsigned HIGH_THRESHOLD    = 9,
    parameter int unsigned HOLD_WINDOWS      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         sample_valid,
    input  logic [SAMPLE_DATA_WIDTH-1:0] sample_data,
    output logic                         span_valid,
    output logic [SAMPLE_DATA_WIDTH-1:0] span,
    output logic                         triggered
);
    localparam int unsigned DW      = SAMPLE_DATA_WIDTH;
    localparam int unsigned CNT_W   = bits_for(LOOK_BACK);
    localparam int unsigned QUIET_W = bits_for(HOLD_WINDOWS + 1);

    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(LOOK_BACK - 1);
    localparam logic [DW-1:0]      LOW_T    = DW'(LOW_THRESHOLD);
    localparam logic [DW-1:0]      HIGH_T   = DW'(HIGH_THRESHOLD);
    localparam logic [QUIET_W-1:0] HOLD_Q   = QUIET_W'(HOLD_WINDOWS);

    logic [CNT_W-1:0]   count;
    logic [DW-1:0]      min_q, max_q;
    logic [DW-1:0]      win_min, win_max, win_span;
    logic               closing;
    env_state_t         state, state_nxt;
    logic [QUIET_W-1:0] quiet, quiet_nxt, quiet_inc;

    // Window statistics including the current sample; count==0 means this
    // sample opens a fresh window, so stale min/max are ignored.
    always_comb begin
        win_min  = (count == '0 || sample_data < min_q) ? sample_data : min_q;
        win_max  = (count == '0 || sample_data > max_q) ? sample_data : max_q;
        win_span = win_max - win_min;
        closing  = sample_valid && (count == LAST_IDX);
    end

    always_comb begin
        state_nxt = state;
        quiet_nxt = quiet;
        quiet_inc = quiet + 1'b1;
        case (state)
            IDLE: begin
                quiet_nxt = '0;
                if (win_span >= HIGH_T) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (win_span <= LOW_T) begin
                    // First quiet window already satisfies a hold of 0 or 1.
                    if (HOLD_WINDOWS <= 1) begin
                        state_nxt = IDLE;
                        quiet_nxt = '0;
                    end else begin
                        state_nxt = RELEASE;
                        quiet_nxt = QUIET_W'(1);
                    end
                end
            end
            RELEASE: begin
                if (win_span > LOW_T) begin
                    state_nxt = ACTIVE;
                    quiet_nxt = '0;
                end else if (quiet_inc >= HOLD_Q) begin
                    state_nxt = IDLE;
                    quiet_nxt = '0;
                end else begin
                    quiet_nxt = quiet_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                quiet_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            span_valid <= 1'b0;
            span       <= '0;
            state      <= IDLE;
            quiet      <= '0;
        end else if (clear) begin
            count      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            span_valid <= 1'b0;
            state      <= IDLE;
            quiet      <= '0;
        end else begin
            span_valid <= closing;
            if (sample_valid) begin
                min_q <= win_min;
                max_q <= win_max;
                if (closing) begin
                    count <= '0;
                    span  <= win_span;
                    state <= state_nxt;
                    quiet <= quiet_nxt;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign triggered = (state != IDLE);

endmodule

// File: rtl/envelope_trigger.sv
// envelope_trigger: multi-channel windowed span detector with hysteresis.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous restart of all channels
//   bus (slave)   : axiiv/axiid/axiic sample input,
//                   span_axiov/span_axiod/span_axioc span result output
//   triggered     : per-channel detection flag
//   any_triggered : OR of triggered
module envelope_trigger
    import envelope_pkg::*;
#(
    parameter int unsigned SAMPLE_DATA_WIDTH = 8,
    parameter int unsigned NUM_CHANNELS      = 2,
    parameter int unsigned LOOK_BACK         = 50,
    parameter int unsigned LOW_THRESHOLD     = 2,
    parameter int unsigned HIGH_THRESHOLD    = 9,
    parameter int unsigned HOLD_WINDOWS      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    envelope_trigger_if.slave       bus,
    output logic [NUM_CHANNELS-1:0] triggered,
    output logic                    any_triggered
);
    localparam int unsigned CHAN_W = bits_for(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0]      ch_span_valid;
    logic [SAMPLE_DATA_WIDTH-1:0] ch_span [NUM_CHANNELS];

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        // Out-of-range channel indices match no instance and are dropped.
        logic ch_valid;
        assign ch_valid = bus.axiiv && !clear && (bus.axiic == CHAN_W'(g));

        envelope_channel #(
            .SAMPLE_DATA_WIDTH (SAMPLE_DATA_WIDTH),
            .LOOK_BACK         (LOOK_BACK),
            .LOW_THRESHOLD     (LOW_THRESHOLD),
            .HIGH_THRESHOLD    (HIGH_THRESHOLD),
            .HOLD_WINDOWS      (HOLD_WINDOWS)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .clear        (clear),
            .sample_valid (ch_valid),
            .sample_data  (bus.axiid),
            .span_valid   (ch_span_valid[g]),
            .span         (ch_span[g]),
            .triggered    (triggered[g])
        );
    end

    // One sample per cycle means at most one channel closes per cycle, so a
    // simple priority pick is exact. Outputs read zero when no pulse.
    always_comb begin
        bus.span_axiov = 1'b0;
        bus.span_axiod = '0;
        bus.span_axioc = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_span_valid[i]) begin
                bus.span_axiov = 1'b1;
                bus.span_axiod = ch_span[i];
                bus.span_axioc = CHAN_W'(i);
            end
        end
    end

    assign any_triggered = |triggered;

endmodule

// File: tb/tb_envelope_trigger.sv
// tb_envelope_trigger: directed self-checking bench for envelope_trigger.
//   dut_a : NUM_CHANNELS=2, LOOK_BACK=4, LOW=2, HIGH=9, HOLD_WINDOWS=1
//   dut_b : NUM_CHANNELS=3, LOOK_BACK=4, LOW=2, HIGH=9, HOLD_WINDOWS=2
//           (3 channels gives a 2-bit index so axiic=3 is expressible)
module tb_envelope_trigger;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_a = 1'b0;
    logic       clear_b = 1'b0;
    logic [1:0] trig_a;
    logic [2:0] trig_b;
    logic       any_a, any_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    envelope_trigger_if #(.DATA_W(8), .CHAN_W(1)) bus_a ();
    envelope_trigger_if #(.DATA_W(8), .CHAN_W(2)) bus_b ();

    envelope_trigger #(
        .SAMPLE_DATA_WIDTH (8),
        .NUM_CHANNELS      (2),
        .LOOK_BACK         (4),
        .LOW_THRESHOLD     (2),
        .HIGH_THRESHOLD    (9),
        .HOLD_WINDOWS      (1)
    ) dut_a (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear_a),
        .bus           (bus_a),
        .triggered     (trig_a),
        .any_triggered (any_a)
    );

    envelope_trigger #(
        .SAMPLE_DATA_WIDTH (8),
        .NUM_CHANNELS      (3),
        .LOOK_BACK         (4),
        .LOW_THRESHOLD     (2),
        .HIGH_THRESHOLD    (9),
        .HOLD_WINDOWS      (2)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear_b),
        .bus           (bus_b),
        .triggered     (trig_b),
        .any_triggered (any_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sample for one cycle, then valid drops; back-to-back calls give
    // samples on consecutive cycles. Returns 1 time unit after the edge.
    task automatic sa(input logic c, input logic [7:0] d);
        bus_a.axiiv = 1'b1;
        bus_a.axiic = c;
        bus_a.axiid = d;
        @(posedge clk);
        #1;
        bus_a.axiiv = 1'b0;
    endtask

    task automatic sb(input logic [1:0] c, input logic [7:0] d);
        bus_b.axiiv = 1'b1;
        bus_b.axiic = c;
        bus_b.axiid = d;
        @(posedge clk);
        #1;
        bus_b.axiiv = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_span_a(input string tag, input logic [7:0] d, input logic c);
        chk({tag, "_v"}, 32'(bus_a.span_axiov), 32'd1);
        chk({tag, "_d"}, 32'(bus_a.span_axiod), 32'(d));
        chk({tag, "_c"}, 32'(bus_a.span_axioc), 32'(c));
    endtask

    task automatic chk_span_b(input string tag, input logic [7:0] d, input logic [1:0] c);
        chk({tag, "_v"}, 32'(bus_b.span_axiov), 32'd1);
        chk({tag, "_d"}, 32'(bus_b.span_axiod), 32'(d));
        chk({tag, "_c"}, 32'(bus_b.span_axioc), 32'(c));
    endtask

    initial begin
        bus_a.axiiv = 1'b0; bus_a.axiic = '0; bus_a.axiid = '0;
        bus_b.axiiv = 1'b0; bus_b.axiic = '0; bus_b.axiid = '0;

        // Reset state
        #2;
        chk("rst_trig",  32'(trig_a), 32'd0);
        chk("rst_any",   32'(any_a), 32'd0);
        chk("rst_spanv", 32'(bus_a.span_axiov), 32'd0);
        chk("rst_spand", 32'(bus_a.span_axiod), 32'd0);
        chk("rst_spanc", 32'(bus_a.span_axioc), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ch0 10,20,15,12 -> span 10, trigger
        sa(1'b0, 8'd10); sa(1'b0, 8'd20); sa(1'b0, 8'd15);
        chk("w1_open", 32'(bus_a.span_axiov), 32'd0);
        sa(1'b0, 8'd12);
        chk_span_a("w1", 8'd10, 1'b0);
        chk("w1_trig", 32'(trig_a), 32'd1);
        chk("w1_any",  32'(any_a), 32'd1);
        idle_cycle();
        chk("w1_pulse_end", 32'(bus_a.span_axiov), 32'd0);
        chk("w1_trig_hold", 32'(trig_a), 32'd1);

        // ch0 50,51,50,51 -> span 1, HOLD=1 releases at once
        sa(1'b0, 8'd50); sa(1'b0, 8'd51); sa(1'b0, 8'd50); sa(1'b0, 8'd51);
        chk_span_a("w2", 8'd1, 1'b0);
        chk("w2_trig", 32'(trig_a), 32'd0);

        // IDLE with span 5 stays IDLE
        sa(1'b0, 8'd10); sa(1'b0, 8'd15); sa(1'b0, 8'd12); sa(1'b0, 8'd11);
        chk_span_a("w3", 8'd5, 1'b0);
        chk("w3_trig", 32'(trig_a), 32'd0);

        // Interleave: ch1 100,112,105,100 (span 12), ch0 7,7,7,7 (span 0)
        sa(1'b1, 8'd100); sa(1'b0, 8'd7);
        sa(1'b1, 8'd112); sa(1'b0, 8'd7);
        sa(1'b1, 8'd105); sa(1'b0, 8'd7);
        chk("il_noclose", 32'(bus_a.span_axiov), 32'd0);
        sa(1'b1, 8'd100);
        chk_span_a("il_ch1", 8'd12, 1'b1);
        chk("il_ch1_trig", 32'(trig_a), 32'd2);
        sa(1'b0, 8'd7);
        chk_span_a("il_ch0", 8'd0, 1'b0);
        chk("il_trig", 32'(trig_a), 32'd2);
        chk("il_any",  32'(any_a), 32'd1);

        // clear with a concurrent sample after two ch0 samples
        sa(1'b0, 8'd1); sa(1'b0, 8'd2);
        clear_a = 1'b1;
        sa(1'b0, 8'd3);
        clear_a = 1'b0;
        chk("clr_trig",  32'(trig_a), 32'd0);
        chk("clr_spanv", 32'(bus_a.span_axiov), 32'd0);
        sa(1'b0, 8'd40); sa(1'b0, 8'd41);
        chk("clr_n2", 32'(bus_a.span_axiov), 32'd0);
        sa(1'b0, 8'd42);
        chk("clr_n3", 32'(bus_a.span_axiov), 32'd0);
        sa(1'b0, 8'd50);
        chk_span_a("clr_w", 8'd10, 1'b0);
        chk("clr_w_trig", 32'(trig_a), 32'd1);

        // Asynchronous reset between edges while triggered and pulsing
        #2;
        rst = 1'b1;
        #1;
        chk("arst_trig",  32'(trig_a), 32'd0);
        chk("arst_spanv", 32'(bus_a.span_axiov), 32'd0);
        chk("arst_spand", 32'(bus_a.span_axiod), 32'd0);
        chk("arst_any",   32'(any_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-window discards the partial window
        sa(1'b0, 8'd0); sa(1'b0, 8'd200);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sa(1'b0, 8'd5); sa(1'b0, 8'd6); sa(1'b0, 8'd7);
        chk("rmw_n3", 32'(bus_a.span_axiov), 32'd0);
        sa(1'b0, 8'd8);
        chk_span_a("rmw", 8'd3, 1'b0);
        chk("rmw_trig", 32'(trig_a), 32'd0);

        // HOLD_WINDOWS=2 on dut_b
        sb(2'd0, 8'd10); sb(2'd0, 8'd20); sb(2'd0, 8'd15); sb(2'd0, 8'd12);
        chk_span_b("h1", 8'd10, 2'd0);
        chk("h1_trig", 32'(trig_b), 32'd1);
        sb(2'd0, 8'd50); sb(2'd0, 8'd51); sb(2'd0, 8'd50); sb(2'd0, 8'd51);
        chk_span_b("h2", 8'd1, 2'd0);
        chk("h2_trig_release", 32'(trig_b), 32'd1);
        sb(2'd0, 8'd10); sb(2'd0, 8'd15); sb(2'd0, 8'd12); sb(2'd0, 8'd11);
        chk_span_b("h3", 8'd5, 2'd0);
        chk("h3_trig_reactive", 32'(trig_b), 32'd1);
        sb(2'd0, 8'd50); sb(2'd0, 8'd51); sb(2'd0, 8'd50); sb(2'd0, 8'd51);
        chk("h4_trig_q1", 32'(trig_b), 32'd1);
        sb(2'd0, 8'd60); sb(2'd0, 8'd60); sb(2'd0, 8'd61); sb(2'd0, 8'd60);
        chk_span_b("h5", 8'd1, 2'd0);
        chk("h5_trig_q2", 32'(trig_b), 32'd0);
        chk("h5_any",     32'(any_b), 32'd0);

        // Out-of-range channel index is ignored
        sb(2'd0, 8'd1); sb(2'd0, 8'd3);
        sb(2'd3, 8'd200); sb(2'd3, 8'd200);
        chk("oor_nopulse", 32'(bus_b.span_axiov), 32'd0);
        sb(2'd0, 8'd2);
        chk("oor_n3", 32'(bus_b.span_axiov), 32'd0);
        sb(2'd0, 8'd2);
        chk_span_b("oor", 8'd2, 2'd0);
        chk("oor_trig", 32'(trig_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/envelope_trigger.md
ENVELOPE_TRIGGER -- requirements
Module: envelope_trigger

Interface
REQ-001 SHALL have parameter SAMPLE_DATA_WIDTH, default 8, unsigned sample width.
REQ-002 SHALL have parameter NUM_CHANNELS, default 2, number of independent channels (>=1).
REQ-003 SHALL have parameter LOOK_BACK, default 50, samples per window per channel (>=1).
REQ-004 SHALL have parameter LOW_THRESHOLD, default 2, release span threshold; SHALL require LOW_THRESHOLD < HIGH_THRESHOLD.
REQ-005 SHALL have parameter HIGH_THRESHOLD, default 9, trigger span threshold.
REQ-006 SHALL have parameter HOLD_WINDOWS, default 1, quiet windows required before release (>=0).
REQ-007 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port axiiv  input  1  sample valid.
REQ-010 SHALL have port axiid  input  SAMPLE_DATA_WIDTH  sample data.
REQ-011 SHALL have port axiic  input  max(1,$clog2(NUM_CHANNELS))  sample channel index.
REQ-012 SHALL have port clear  input  1  synchronous restart of all windows and states.
REQ-013 SHALL have port triggered  output  NUM_CHANNELS  per-channel detection flag.
REQ-014 SHALL have port any_triggered  output  1  OR of triggered.
REQ-015 SHALL have port span_axiov  output  1  one-cycle pulse: window span result valid.
REQ-016 SHALL have port span_axiod  output  SAMPLE_DATA_WIDTH  window span (max-min).
REQ-017 SHALL have port span_axioc  output  width of axiic  channel of span result.

Function
REQ-018 SHALL accept a sample when axiiv=1, clear=0, axiic<NUM_CHANNELS; samples with axiic>=NUM_CHANNELS SHALL be ignored.
REQ-019 SHALL keep per channel running min, max, and sample count; first sample of a window loads min=max=sample.
REQ-020 SHALL close a window (tumbling, non-overlapping) when the LOOK_BACK-th sample of that channel is accepted; LOOK_BACK=1 closes every sample.
REQ-021 SHALL assert span_axiov exactly one cycle after the closing sample, with span_axiod=max-min (including closing sample, unsigned, no overflow since max>=min) and span_axioc=channel.
REQ-022 SHALL run a per-channel FSM IDLE/ACTIVE/RELEASE evaluated only at window close, new state visible on triggered the same cycle as span_axiov.
REQ-023 IDLE: span>=HIGH_THRESHOLD -> ACTIVE; else stay.
REQ-024 ACTIVE: span<=LOW_THRESHOLD -> RELEASE with quiet count=1, or IDLE directly if HOLD_WINDOWS=0 or 1 is reached (quiet count>=HOLD_WINDOWS); else stay.
REQ-025 RELEASE: span>LOW_THRESHOLD -> ACTIVE, quiet count cleared; span<=LOW_THRESHOLD increments quiet count, -> IDLE when count reaches HOLD_WINDOWS.
REQ-026 triggered[c] SHALL be 1 in ACTIVE and RELEASE, 0 in IDLE; any_triggered SHALL be combinational OR.
REQ-027 Channels SHALL be fully independent; interleaved samples SHALL not affect other channels' windows.
REQ-028 clear=1 SHALL, next edge, zero all counts, set all FSMs IDLE, drop any concurrent sample, and suppress span_axiov that cycle; clear wins over axiiv.
REQ-029 Sample acceptance SHALL be every cycle (no backpressure); throughput one sample/clk.

Reset
REQ-030 rst=1 SHALL asynchronously force triggered=0, span_axiov=0, span_axiod=0, span_axioc=0, all FSMs IDLE, all counts/min/max 0.
REQ-031 rst mid-window SHALL discard partial window; first accepted sample after release starts a new window.

Structure
REQ-032 A shared package envelope_pkg SHALL hold the FSM state typedef (IDLE, ACTIVE, RELEASE).
REQ-033 Per-channel datapath and FSM SHALL be sub-module envelope_channel, instantiated NUM_CHANNELS times by generate; top-level muxes span outputs (at most one channel closes per cycle).

Verification (LOOK_BACK=4, LOW=2, HIGH=9, HOLD=1, NUM_CHANNELS=2)
REQ-034 ch0 samples 10,20,15,12 on consecutive cycles -> next cycle span_axiov=1, span_axiod=10, span_axioc=0, triggered=2'b01.
REQ-035 then ch0 50,51,50,51 -> span 1, triggered[0] drops to 0 (HOLD=1 reached); repeat with HOLD=2 -> stays 1 one window, drops after second quiet window.
REQ-036 IDLE ch0 window span 5 -> triggered[0]=0; in RELEASE (HOLD=2) window span 5 -> returns ACTIVE, triggered[0] stays 1.
REQ-037 interleave ch0/ch1 (ch1 span 12, ch0 span 0) -> two separate span pulses, triggered=2'b10, any_triggered=1.
REQ-038 clear with axiiv in same cycle after 2 ch0 samples -> no span pulse until 4 further ch0 samples accepted; axiic=3 samples ignored.
REQ-039 rst asserted between clock edges while triggered=1 -> triggered, span_axiov go 0 immediately, before next edge.
